switch_port: RTL

SWITCH_PORT -- requirements
Module: switch_port

---
 rtl/switch_port.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/switch_port.sv
// switch_port: CPU-readable bank of board switches with change flags.
// Raw switches are synchronized, optionally debounced (build with the
// SWITCH_DEBOUNCE_EN macro), held in a stable register, and every change of
// a stable bit raises a sticky write-1-to-clear flag that drives a level IRQ.
// All state advances on the falling edge of switclk; switrst is asynchronous.
module switch_port #(
  parameter int SW_WIDTH   = 24,
  parameter int DEB_CYCLES = 20000
) (
  input  logic                switclk,
  input  logic                switrst,
  input  logic                switchcs,
  input  logic                switchread,
  input  logic                switchwrite,
  input  logic [2:0]          switchaddr,
  input  logic [15:0]         switchwdata,
  output logic [15:0]         switchrdata,
  input  logic [SW_WIDTH-1:0] switch_i,
  output logic                switchirq
);

  localparam int W = SW_WIDTH;

  logic [W-1:0] r_sync_p0;
  logic [W-1:0] r_sync_p1;
  logic [1:0]   r_svld;
  logic [W-1:0] r_stab;
  logic         r_stab_vld;
  logic [W-1:0] r_flag;
  logic [15:0]  r_rdata;
  logic         r_irq;

  logic         w_rd;
  logic         w_wr_flag;
  logic [W-1:0] w_stab_nxt;
  logic         w_stab_vld_nxt;
  logic [W-1:0] w_set;
  logic [W-1:0] w_clr;
  logic [W-1:0] w_flag_nxt;
  logic [31:0]  w_stab32;
  logic [31:0]  w_flag32;
  logic [15:0]  w_rmux;
  logic         w_unused;

  // Address bit 0, write-data bits beyond the switch count and (in the plain
  // build) DEB_CYCLES have no function.
  assign w_unused = switchaddr[0] ^ (^switchwdata) ^ (DEB_CYCLES < 2);

  assign w_rd      = switchcs && switchread;
  assign w_wr_flag = switchcs && switchwrite && switchaddr[2];

  // Two-flop synchronizer; r_svld marks when r_sync_p1 holds a real sample.
  always_ff @(negedge switclk or posedge switrst) begin
    if (switrst) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
      r_svld    <= 2'b00;
    end else begin
      r_sync_p0 <= switch_i;
      r_sync_p1 <= r_sync_p0;
      r_svld    <= {r_svld[0], 1'b1};
    end
  end

`ifdef SWITCH_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_snap;
  logic             r_snap_vld;
  logic             w_tick;
  logic [W-1:0]     w_eq;

  assign w_tick = (r_cnt == CNT_W'(DEB_CYCLES - 1));

  // Sample-tick divider and per-bit snapshot taken at every tick.
  always_ff @(negedge switclk or posedge switrst) begin
    if (switrst) begin
      r_cnt      <= '0;
      r_snap     <= '0;
      r_snap_vld <= 1'b0;
    end else if (w_tick) begin
      r_cnt      <= '0;
      r_snap     <= r_sync_p1;
      r_snap_vld <= r_snap_vld | r_svld[1];
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A bit is accepted only when it matched at two consecutive ticks.
  assign w_eq           = ~(r_sync_p1 ^ r_snap);
  assign w_stab_nxt     = (w_tick && r_snap_vld) ?
                          ((r_stab & ~w_eq) | (r_sync_p1 & w_eq)) : r_stab;
  assign w_stab_vld_nxt = r_stab_vld | (w_tick & r_snap_vld);
`else
  assign w_stab_nxt     = r_sync_p1;
  assign w_stab_vld_nxt = r_svld[1];
`endif

  // Change events are suppressed until stab has held one real sample, so the
  // first load after reset never raises a flag.
  assign w_set = (w_stab_nxt ^ r_stab) & {W{r_stab_vld}};

  // Write-1-to-clear mask: addr 10 covers bits 15:0, addr 11 bits 31:16.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < W; i++) begin
      w_clr[i] = w_wr_flag && (switchaddr[1] == (i >= 16)) && switchwdata[i % 16];
    end
  end

  // Set wins over a same-edge clear.
  assign w_flag_nxt = (r_flag & ~w_clr) | w_set;

  // Stable value and sticky change flags.
  always_ff @(negedge switclk or posedge switrst) begin
    if (switrst) begin
      r_stab     <= '0;
      r_stab_vld <= 1'b0;
      r_flag     <= '0;
    end else begin
      r_stab     <= w_stab_nxt;
      r_stab_vld <= w_stab_vld_nxt;
      r_flag     <= w_flag_nxt;
    end
  end

  // Zero-extend both registers to the 32-bit read window.
  always_comb begin
    w_stab32        = '0;
    w_flag32        = '0;
    w_stab32[W-1:0] = r_stab;
    w_flag32[W-1:0] = r_flag;
  end

  // Read map; flags are read pre-edge so a coinciding clear is not visible.
  always_comb begin
    w_rmux = 16'h0000;
    case (switchaddr[2:1])
      2'b00:   w_rmux = w_stab32[15:0];
      2'b01:   w_rmux = w_stab32[31:16];
      2'b10:   w_rmux = w_flag32[15:0];
      default: w_rmux = w_flag32[31:16];
    endcase
  end

  // Registered read data and interrupt level.
  always_ff @(negedge switclk or posedge switrst) begin
    if (switrst) begin
      r_rdata <= 16'h0000;
      r_irq   <= 1'b0;
    end else begin
      if (w_rd) begin
        r_rdata <= w_rmux;
      end
      r_irq <= |r_flag;
    end
  end

  assign switchrdata = r_rdata;
  assign switchirq   = r_irq;

endmodule
